// File: rtl/sram_ctrl_pkg.sv
// Shared defaults and active-low port encodings for the sky130 1rw SRAM request engine.
package sram_ctrl_pkg;

    localparam int DATA_BIT_DEF  = 32;
    localparam int ADDR_BIT_DEF  = 8;
    localparam int RSP_DEPTH_DEF = 4;

    localparam logic CSB_IDLE = 1'b1;
    localparam logic WEB_READ = 1'b1;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Synchronous response FIFO: head is presented combinationally, and pointers wrap modulo RSP_DEPTH.
module sram_rsp_fifo
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_BIT  = DATA_BIT_DEF,
    parameter int RSP_DEPTH = RSP_DEPTH_DEF,
    parameter int CNT_W     = cnt_width(RSP_DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic [DATA_BIT-1:0] push_data,
    input  logic                pop,
    output logic [DATA_BIT-1:0] head,
    output logic [CNT_W-1:0]    count,
    output logic                empty,
    output logic                full
);

    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic [DATA_BIT-1:0] mem_q [RSP_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        do_pop   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = next_ptr(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        case ({push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(RSP_DEPTH));
    assign count = count_q;
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/sram_sp_initiator.sv
// Request-side engine for the sky130 1rw SRAM macro with a credit-protected read response FIFO.
// Define SRAM_PERF_CNT_EN to add the rd_cnt/wr_cnt accepted-request counters.
module sram_sp_initiator
    import sram_ctrl_pkg::*;
#(
    parameter int DATA_BIT  = DATA_BIT_DEF,
    parameter int ADDR_BIT  = ADDR_BIT_DEF,
    parameter int RSP_DEPTH = RSP_DEPTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_BIT-1:0] req_addr,
    input  logic [DATA_BIT-1:0] req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_BIT-1:0] rsp_rdata,
    output logic                csb0,
    output logic                web0,
    output logic [ADDR_BIT-1:0] addr0,
    output logic [DATA_BIT-1:0] din0,
    input  logic [DATA_BIT-1:0] dout0
`ifdef SRAM_PERF_CNT_EN
    ,
    output logic [31:0]         rd_cnt,
    output logic [31:0]         wr_cnt
`endif
);

    localparam int CNT_W = cnt_width(RSP_DEPTH);
    localparam int SUM_W = CNT_W + 1;

    logic                csb0_q, csb0_d;
    logic                web0_q, web0_d;
    logic [ADDR_BIT-1:0] addr0_q, addr0_d;
    logic [DATA_BIT-1:0] din0_q, din0_d;
    logic                rd_s1_q, rd_s1_d;
    logic                rd_s2_q, rd_s2_d;
    logic                req_ready_q, req_ready_d;

    logic                accept;
    logic                pop;
    logic                push;
    logic [SUM_W-1:0]    inflight_d;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_empty;
    logic                fifo_full;

    always_comb begin
        accept  = req_valid && req_ready_q;
        pop     = !fifo_empty && rsp_ready;
        push    = rd_s2_q && (!fifo_full || pop);

        csb0_d  = CSB_IDLE;
        web0_d  = web0_q;
        addr0_d = addr0_q;
        din0_d  = din0_q;
        rd_s1_d = 1'b0;
        if (accept) begin
            csb0_d  = ~CSB_IDLE;
            web0_d  = req_we ? ~WEB_READ : WEB_READ;
            addr0_d = req_addr;
            din0_d  = req_wdata;
            rd_s1_d = ~req_we;
        end
        rd_s2_d = rd_s1_q;

        // Every read in flight or parked in the FIFO holds one credit after this edge.
        inflight_d  = SUM_W'(fifo_count) + SUM_W'(push) - SUM_W'(pop)
                    + SUM_W'(rd_s1_d) + SUM_W'(rd_s2_d);
        req_ready_d = (inflight_d < SUM_W'(RSP_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csb0_q      <= CSB_IDLE;
            web0_q      <= WEB_READ;
            addr0_q     <= '0;
            din0_q      <= '0;
            rd_s1_q     <= 1'b0;
            rd_s2_q     <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            csb0_q      <= csb0_d;
            web0_q      <= web0_d;
            addr0_q     <= addr0_d;
            din0_q      <= din0_d;
            rd_s1_q     <= rd_s1_d;
            rd_s2_q     <= rd_s2_d;
            req_ready_q <= req_ready_d;
        end
    end

    // dout0 is only meaningful in the cycle after the macro sampled a read.
    sram_rsp_fifo #(
        .DATA_BIT  (DATA_BIT),
        .RSP_DEPTH (RSP_DEPTH),
        .CNT_W     (CNT_W)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (dout0),
        .pop       (pop),
        .head      (rsp_rdata),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign req_ready = req_ready_q;
    assign rsp_valid = !fifo_empty;
    assign csb0      = csb0_q;
    assign web0      = web0_q;
    assign addr0     = addr0_q;
    assign din0      = din0_q;

`ifdef SRAM_PERF_CNT_EN
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;

    always_comb begin
        rd_cnt_d = rd_cnt_q + 32'(accept && !req_we);
        wr_cnt_d = wr_cnt_q + 32'(accept && req_we);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
`endif

endmodule
